// File: rtl/cfg_mgmt_access_arb_if.sv
// Bundle of requester-side and core-side cfg_mgmt signals for the access arbiter.
// The master modport is the arbiter; the slave modport is the requesters plus the PCIe core.
interface cfg_mgmt_access_arb_if #(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 10
);
  logic [NUM_CH-1:0]        ch_req;
  logic [NUM_CH-1:0]        ch_wr;
  logic [NUM_CH-1:0]        ch_type1;
  logic [NUM_CH*ADDR_W-1:0] ch_addr;
  logic [NUM_CH*32-1:0]     ch_wdata;
  logic [NUM_CH*4-1:0]      ch_be;
  logic [NUM_CH-1:0]        ch_done;
  logic [31:0]              ch_rdata;
  logic                     ch_timeout;

  logic [ADDR_W-1:0]        cfg_mgmt_addr;
  logic                     cfg_mgmt_write;
  logic                     cfg_mgmt_read;
  logic [31:0]              cfg_mgmt_write_data;
  logic [3:0]               cfg_mgmt_byte_enable;
  logic                     cfg_mgmt_type1_cfg_reg_access;
  logic [31:0]              cfg_mgmt_read_data;
  logic                     cfg_mgmt_read_write_done;

  modport master (
    input  ch_req, ch_wr, ch_type1, ch_addr, ch_wdata, ch_be,
    output ch_done, ch_rdata, ch_timeout,
    output cfg_mgmt_addr, cfg_mgmt_write, cfg_mgmt_read, cfg_mgmt_write_data,
    output cfg_mgmt_byte_enable, cfg_mgmt_type1_cfg_reg_access,
    input  cfg_mgmt_read_data, cfg_mgmt_read_write_done
  );

  modport slave (
    output ch_req, ch_wr, ch_type1, ch_addr, ch_wdata, ch_be,
    input  ch_done, ch_rdata, ch_timeout,
    input  cfg_mgmt_addr, cfg_mgmt_write, cfg_mgmt_read, cfg_mgmt_write_data,
    input  cfg_mgmt_byte_enable, cfg_mgmt_type1_cfg_reg_access,
    output cfg_mgmt_read_data, cfg_mgmt_read_write_done
  );
endinterface

// File: rtl/cfg_mgmt_access_arb.sv
// Round-robin sequencer sharing the PCIe cfg_mgmt port among NUM_CH requesters,
// with a per-access timeout and a saturating count of aborted accesses.
module cfg_mgmt_access_arb #(
  parameter int NUM_CH      = 4,
  parameter int ADDR_W      = 10,
  parameter int TIMEOUT_CYC = 1024,
  parameter int ERRCNT_W    = 16
) (
  input  logic                       user_clk,
  input  logic                       user_reset_n,
  cfg_mgmt_access_arb_if.master      bus,
  output logic                       busy,
  output logic [ERRCNT_W-1:0]        timeout_cnt
);

  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_GAP    = 2'd2
  } state_t;

  state_t              r_state;
  logic [PTR_W-1:0]    r_rr_ptr;
  logic [PTR_W-1:0]    r_grant;
  logic                r_wr;
  logic [CNT_W-1:0]    r_wait_cnt;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_write;
  logic                r_read;
  logic [31:0]         r_wdata;
  logic [3:0]          r_be;
  logic                r_type1;
  logic [NUM_CH-1:0]   r_ch_done;
  logic [31:0]         r_ch_rdata;
  logic                r_ch_timeout;
  logic                r_busy;
  logic [ERRCNT_W-1:0] r_timeout_cnt;

  logic                w_found;
  logic [PTR_W-1:0]    w_grant;
  logic [PTR_W-1:0]    w_next_ptr;

  function automatic logic [NUM_CH-1:0] onehot(input logic [PTR_W-1:0] idx);
    logic [NUM_CH-1:0] v;
    v = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      v[k] = (int'(idx) == k);
    end
    return v;
  endfunction

  // First requesting channel at or above rr_ptr, wrapping around.
  always_comb begin : p_grant
    int   idx;
    logic take;
    w_found = 1'b0;
    w_grant = '0;
    idx     = 0;
    take    = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx     = int'(r_rr_ptr) + i;
      idx     = (idx >= NUM_CH) ? idx - NUM_CH : idx;
      take    = !w_found && bus.ch_req[idx];
      w_grant = take ? PTR_W'(idx) : w_grant;
      w_found = w_found | take;
    end
  end

  assign w_next_ptr = (int'(r_grant) == NUM_CH - 1) ? '0 : r_grant + 1'b1;

  // Access sequencer: grant, hold the strobe, complete or abort, then one idle gap.
  always_ff @(posedge user_clk) begin
    if (!user_reset_n) begin
      r_state       <= S_IDLE;
      r_rr_ptr      <= '0;
      r_grant       <= '0;
      r_wr          <= 1'b0;
      r_wait_cnt    <= '0;
      r_addr        <= '0;
      r_write       <= 1'b0;
      r_read        <= 1'b0;
      r_wdata       <= 32'h0000_0000;
      r_be          <= 4'h0;
      r_type1       <= 1'b0;
      r_ch_done     <= '0;
      r_ch_rdata    <= 32'h0000_0000;
      r_ch_timeout  <= 1'b0;
      r_busy        <= 1'b0;
      r_timeout_cnt <= '0;
    end else begin
      r_ch_done    <= '0;
      r_ch_rdata   <= 32'h0000_0000;
      r_ch_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant    <= w_grant;
            r_wr       <= bus.ch_wr[w_grant];
            r_addr     <= bus.ch_addr[int'(w_grant)*ADDR_W +: ADDR_W];
            r_type1    <= bus.ch_type1[w_grant];
            r_wait_cnt <= '0;
            r_busy     <= 1'b1;
            r_state    <= S_ACCESS;
            if (bus.ch_wr[w_grant]) begin
              r_wdata <= bus.ch_wdata[int'(w_grant)*32 +: 32];
              r_be    <= bus.ch_be[int'(w_grant)*4 +: 4];
              r_write <= 1'b1;
              r_read  <= 1'b0;
            end else begin
              r_write <= 1'b0;
              r_read  <= 1'b1;
            end
          end else begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_ACCESS: begin
          // A done in the final wait cycle still counts as a normal completion.
          if (bus.cfg_mgmt_read_write_done) begin
            r_read     <= 1'b0;
            r_write    <= 1'b0;
            r_addr     <= '0;
            r_be       <= 4'h0;
            r_ch_done  <= onehot(r_grant);
            r_ch_rdata <= r_wr ? 32'h0000_0000 : bus.cfg_mgmt_read_data;
            r_state    <= S_GAP;
          end else if (r_wait_cnt == WAIT_LAST) begin
            r_read       <= 1'b0;
            r_write      <= 1'b0;
            r_ch_done    <= onehot(r_grant);
            r_ch_timeout <= 1'b1;
            if (r_timeout_cnt != {ERRCNT_W{1'b1}}) begin
              r_timeout_cnt <= r_timeout_cnt + 1'b1;
            end else begin
              r_timeout_cnt <= r_timeout_cnt;
            end
            r_state <= S_GAP;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        S_GAP: begin
          r_rr_ptr <= w_next_ptr;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: begin
          r_read  <= 1'b0;
          r_write <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ch_done                       = r_ch_done;
  assign bus.ch_rdata                      = r_ch_rdata;
  assign bus.ch_timeout                    = r_ch_timeout;
  assign bus.cfg_mgmt_addr                 = r_addr;
  assign bus.cfg_mgmt_write                = r_write;
  assign bus.cfg_mgmt_read                 = r_read;
  assign bus.cfg_mgmt_write_data           = r_wdata;
  assign bus.cfg_mgmt_byte_enable          = r_be;
  assign bus.cfg_mgmt_type1_cfg_reg_access = r_type1;
  assign busy                              = r_busy;
  assign timeout_cnt                       = r_timeout_cnt;

endmodule

// File: tb/tb_cfg_mgmt_access_arb.sv
// Directed bench for cfg_mgmt_access_arb: read, write, round-robin, timeout,
// saturation, done-vs-timeout tie and reset mid-access.
module tb_cfg_mgmt_access_arb;
  localparam int NCH = 4;
  localparam int AW  = 10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       busy;
  logic [1:0] timeout_cnt;
  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  int         last_cyc = 0;

  logic [9:0] rr_addr_exp [5] = '{10'h010, 10'h011, 10'h012, 10'h013, 10'h010};
  logic [3:0] rr_done_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [1:0] sat_exp     [3] = '{2'd2, 2'd3, 2'd3};

  always #5 clk = ~clk;

  cfg_mgmt_access_arb_if #(.NUM_CH(NCH), .ADDR_W(AW)) bus ();

  cfg_mgmt_access_arb #(
    .NUM_CH(NCH), .ADDR_W(AW), .TIMEOUT_CYC(16), .ERRCNT_W(2)
  ) dut (
    .user_clk    (clk),
    .user_reset_n(rst_n),
    .bus         (bus),
    .busy        (busy),
    .timeout_cnt (timeout_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_ch(input int ch, input logic wr, input logic t1, input logic [9:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be);
    bus.ch_wr[ch]            = wr;
    bus.ch_type1[ch]         = t1;
    bus.ch_addr[ch*AW +: AW] = addr;
    bus.ch_wdata[ch*32 +: 32] = wdata;
    bus.ch_be[ch*4 +: 4]     = be;
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    bus.ch_req = '0; bus.ch_wr = '0; bus.ch_type1 = '0;
    bus.ch_addr = '0; bus.ch_wdata = '0; bus.ch_be = '0;
    bus.cfg_mgmt_read_data = 32'h0; bus.cfg_mgmt_read_write_done = 1'b0;
    tick(); tick();
    chk("rst_read", bus.cfg_mgmt_read, 1'b0);
    chk("rst_write", bus.cfg_mgmt_write, 1'b0);
    chk("rst_addr", bus.cfg_mgmt_addr, 10'h000);
    chk("rst_done", bus.ch_done, 4'b0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_tcnt", timeout_cnt, 2'd0);
    rst_n = 1'b1;

    // single read on ch0, done 5 cycles after strobe
    set_ch(0, 1'b0, 1'b0, 10'h004, 32'h0, 4'h0);
    bus.ch_req[0] = 1'b1;
    tick();
    chk("rd_strobe", bus.cfg_mgmt_read, 1'b1);
    chk("rd_nowrite", bus.cfg_mgmt_write, 1'b0);
    chk("rd_addr", bus.cfg_mgmt_addr, 10'h004);
    chk("rd_busy", busy, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rd_hold", bus.cfg_mgmt_read, 1'b1);
    end
    bus.cfg_mgmt_read_write_done = 1'b1;
    bus.cfg_mgmt_read_data = 32'h1234_5678;
    tick();
    bus.cfg_mgmt_read_write_done = 1'b0;
    bus.ch_req[0] = 1'b0;
    chk("rd_drop", bus.cfg_mgmt_read, 1'b0);
    chk("rd_addr_clr", bus.cfg_mgmt_addr, 10'h000);
    chk("rd_chdone", bus.ch_done, 4'b0001);
    chk("rd_rdata", bus.ch_rdata, 32'h1234_5678);
    chk("rd_tmo", bus.ch_timeout, 1'b0);
    tick();
    chk("rd_done_clr", bus.ch_done, 4'b0000);
    chk("rd_rdata_clr", bus.ch_rdata, 32'h0);
    chk("rd_idle", busy, 1'b0);

    // write on ch2 with type1
    set_ch(2, 1'b1, 1'b1, 10'h001, 32'h0000_0147, 4'hF);
    bus.ch_req[2] = 1'b1;
    tick();
    chk("wr_strobe", bus.cfg_mgmt_write, 1'b1);
    chk("wr_noread", bus.cfg_mgmt_read, 1'b0);
    chk("wr_type1", bus.cfg_mgmt_type1_cfg_reg_access, 1'b1);
    chk("wr_addr", bus.cfg_mgmt_addr, 10'h001);
    chk("wr_data", bus.cfg_mgmt_write_data, 32'h0000_0147);
    chk("wr_be", bus.cfg_mgmt_byte_enable, 4'hF);
    bus.cfg_mgmt_read_write_done = 1'b1;
    bus.cfg_mgmt_read_data = 32'hFFFF_FFFF;
    tick();
    bus.cfg_mgmt_read_write_done = 1'b0;
    bus.ch_req[2] = 1'b0;
    chk("wr_drop", bus.cfg_mgmt_write, 1'b0);
    chk("wr_chdone", bus.ch_done, 4'b0100);
    chk("wr_rdata", bus.ch_rdata, 32'h0);
    tick();

    // round-robin: all requests high from reset, done one cycle after strobe
    rst_n = 1'b0;
    for (int i = 0; i < NCH; i++) set_ch(i, 1'b0, 1'b0, 10'h010 + 10'(i), 32'h0, 4'h0);
    bus.ch_req = 4'b1111;
    tick(); tick();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      n = 0;
      while (bus.cfg_mgmt_read !== 1'b1 && n < 10) begin
        tick();
        n++;
      end
      chk("rr_strobe", bus.cfg_mgmt_read, 1'b1);
      chk("rr_addr", bus.cfg_mgmt_addr, rr_addr_exp[k]);
      if (k > 0) chk("rr_spacing", cyc - last_cyc, 3);
      last_cyc = cyc;
      bus.cfg_mgmt_read_write_done = 1'b1;
      tick();
      bus.cfg_mgmt_read_write_done = 1'b0;
      chk("rr_chdone", bus.ch_done, rr_done_exp[k]);
    end
    bus.ch_req = 4'b0000;
    tick();

    // timeout on ch1, then a late done that must be ignored
    set_ch(1, 1'b0, 1'b0, 10'h3FF, 32'h0, 4'h0);
    bus.ch_req[1] = 1'b1;
    tick();
    chk("to_strobe", bus.cfg_mgmt_read, 1'b1);
    n = 1;
    do begin
      tick();
      if (bus.cfg_mgmt_read === 1'b1) n++;
    end while (bus.cfg_mgmt_read === 1'b1 && n < 40);
    chk("to_len", n, 16);
    chk("to_chdone", bus.ch_done, 4'b0010);
    chk("to_flag", bus.ch_timeout, 1'b1);
    chk("to_rdata", bus.ch_rdata, 32'h0);
    chk("to_cnt", timeout_cnt, 2'd1);
    bus.ch_req[1] = 1'b0;
    bus.cfg_mgmt_read_write_done = 1'b1;
    bus.cfg_mgmt_read_data = 32'hDEAD_BEEF;
    tick();
    chk("late_chdone0", bus.ch_done, 4'b0000);
    chk("late_flag0", bus.ch_timeout, 1'b0);
    tick();
    chk("late_chdone1", bus.ch_done, 4'b0000);
    chk("late_read", bus.cfg_mgmt_read, 1'b0);
    bus.cfg_mgmt_read_write_done = 1'b0;
    chk("late_cnt", timeout_cnt, 2'd1);

    // done arriving on the last wait cycle beats the timeout (ch0, rr_ptr=2)
    set_ch(0, 1'b0, 1'b0, 10'h020, 32'h0, 4'h0);
    bus.ch_req[0] = 1'b1;
    tick();
    chk("co_strobe", bus.cfg_mgmt_addr, 10'h020);
    for (int i = 0; i < 15; i++) tick();
    chk("co_hold", bus.cfg_mgmt_read, 1'b1);
    bus.cfg_mgmt_read_write_done = 1'b1;
    bus.cfg_mgmt_read_data = 32'hCAFE_F00D;
    tick();
    bus.cfg_mgmt_read_write_done = 1'b0;
    bus.ch_req[0] = 1'b0;
    chk("co_chdone", bus.ch_done, 4'b0001);
    chk("co_flag", bus.ch_timeout, 1'b0);
    chk("co_rdata", bus.ch_rdata, 32'hCAFE_F00D);
    chk("co_cnt", timeout_cnt, 2'd1);
    tick();

    // three more timeouts on ch1: counter saturates at 3
    for (int k = 0; k < 3; k++) begin
      bus.ch_req[1] = 1'b1;
      tick();
      n = 0;
      while (bus.cfg_mgmt_read === 1'b1 && n < 40) begin
        tick();
        n++;
      end
      chk("sat_flag", bus.ch_timeout, 1'b1);
      chk("sat_cnt", timeout_cnt, sat_exp[k]);
      bus.ch_req[1] = 1'b0;
      tick();
    end

    // reset mid-access on ch2 with rr_ptr=2, then ch1 and ch3 compete
    set_ch(2, 1'b0, 1'b0, 10'h055, 32'h0, 4'h0);
    bus.ch_req[2] = 1'b1;
    tick(); tick(); tick();
    chk("mr_active", bus.cfg_mgmt_read, 1'b1);
    rst_n = 1'b0;
    tick();
    chk("mr_read", bus.cfg_mgmt_read, 1'b0);
    chk("mr_busy", busy, 1'b0);
    chk("mr_chdone0", bus.ch_done, 4'b0000);
    chk("mr_cnt", timeout_cnt, 2'd0);
    tick();
    chk("mr_chdone1", bus.ch_done, 4'b0000);
    rst_n = 1'b1;
    bus.ch_req = 4'b0000;
    set_ch(1, 1'b0, 1'b0, 10'h0AA, 32'h0, 4'h0);
    set_ch(3, 1'b0, 1'b0, 10'h0CC, 32'h0, 4'h0);
    bus.ch_req = 4'b1010;
    tick();
    chk("mr_regrant", bus.cfg_mgmt_read, 1'b1);
    chk("mr_addr", bus.cfg_mgmt_addr, 10'h0AA);
    bus.cfg_mgmt_read_write_done = 1'b1;
    bus.cfg_mgmt_read_data = 32'h0BAD_CAFE;
    tick();
    bus.cfg_mgmt_read_write_done = 1'b0;
    bus.ch_req = 4'b0000;
    chk("mr_chdone", bus.ch_done, 4'b0010);
    chk("mr_rdata", bus.ch_rdata, 32'h0BAD_CAFE);
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cfg_mgmt_access_arb.md
Name: cfg_mgmt_access_arb

Overview:
- Multi-channel sequencer for the PCIe core configuration management port in the RP model. It arbitrates between NUM_CH independent requesters (e.g. enumeration, link monitor, error poller) with round-robin priority.
- For the granted requester it drives one cfg_mgmt read or write, holds the strobe until cfg_mgmt_read_write_done, and returns data or a timeout status.
- It is the synthesizable, parametrised, timeout-protected successor of the single-user cfg DW read/write tasks.

Parameters:
- NUM_CH, 4, number of requester channels (1..8).
- ADDR_W, 10, cfg_mgmt DW address width.
- TIMEOUT_CYC, 1024, cycles a strobe may be held without done before abort (>=4).
- ERRCNT_W, 16, width of saturating timeout counter.

Ports:
- user_clk  in  1  clock; all logic on rising edge.
- user_reset_n  in  1  synchronous, active-low reset.
- ch_req  in  NUM_CH  per-channel request level; held until matching ch_done.
- ch_wr  in  NUM_CH  1=write, 0=read; stable while ch_req.
- ch_type1  in  NUM_CH  drives cfg_mgmt_type1_cfg_reg_access for that access.
- ch_addr  in  NUM_CH*ADDR_W  packed DW addresses, channel i at [i*ADDR_W +: ADDR_W].
- ch_wdata  in  NUM_CH*32  packed write data.
- ch_be  in  NUM_CH*4  packed byte enables.
- ch_done  out  NUM_CH  one-cycle completion pulse, one-hot.
- ch_rdata  out  32  read data, valid with ch_done.
- ch_timeout  out  1  valid with ch_done; 1 = access aborted.
- cfg_mgmt_addr  out  ADDR_W  to core.
- cfg_mgmt_write  out  1  write strobe.
- cfg_mgmt_read  out  1  read strobe.
- cfg_mgmt_write_data  out  32  to core.
- cfg_mgmt_byte_enable  out  4  to core.
- cfg_mgmt_type1_cfg_reg_access  out  1  to core.
- cfg_mgmt_read_data  in  32  from core.
- cfg_mgmt_read_write_done  in  1  completion from core.
- busy  out  1  high in any state but IDLE.
- timeout_cnt  out  ERRCNT_W  saturating count of aborted accesses.

Behaviour:
- Reset (user_reset_n=0 at an edge): all outputs 0, state IDLE, rr_ptr=0, timeout_cnt=0. Reset mid-access drops the strobe at that edge; no ch_done is issued for the aborted access.
- States: IDLE -> ACCESS -> GAP -> IDLE.
- IDLE: if any ch_req, grant = first set bit searching from rr_ptr upward with wrap.
  - Latch that channel's addr/wdata/be/type1/wr into cfg_mgmt_* outputs.
  - Assert cfg_mgmt_write (wr=1) or cfg_mgmt_read (wr=0) at the same edge; clear wait_cnt; go ACCESS.
  - cfg_mgmt_write_data and cfg_mgmt_byte_enable are driven only for writes; they hold the previous value for reads.
- ACCESS: hold all cfg_mgmt_* outputs stable; wait_cnt increments each cycle.
  - done=1 sampled: deassert strobe, clear addr/be. Pulse ch_done[grant] next cycle with ch_rdata=cfg_mgmt_read_data (reads) or 0 (writes), ch_timeout=0. Go GAP.
  - Else if wait_cnt==TIMEOUT_CYC-1: deassert strobe, pulse ch_done[grant] with ch_timeout=1 and ch_rdata=0. timeout_cnt increments, saturating at all-ones. Go GAP.
  - done and timeout in the same cycle: done wins.
- GAP: exactly one cycle, strobes low; rr_ptr = (grant+1) mod NUM_CH; go IDLE.
- Latency: req seen at edge t -> strobe high from t+1 -> done sampled at edge d -> ch_done at d+1 -> earliest next strobe d+3.
- ch_req dropped during ACCESS is ignored; the access completes and ch_done is still pulsed.
- A requester must not reassert ch_req in the cycle of its own ch_done pulse. The arbiter samples requests only in IDLE, so the earliest a re-request can be granted is the next IDLE.
- cfg_mgmt_read_write_done outside ACCESS is ignored.
- ch_done, ch_rdata and ch_timeout are registered; ch_rdata and ch_timeout return to 0 the cycle after the pulse.
- cfg_mgmt_read and cfg_mgmt_write are never high together.

Test Plan:
- Single read: ch0 req, wr=0, addr=0x004; core asserts done 5 cycles after strobe with data 0x12345678 -> cfg_mgmt_read high 5 cycles, addr=0x004, ch_done[0] pulse with ch_rdata=0x12345678, ch_timeout=0.
- Write: ch2 wr=1, addr=0x001, wdata=0x00000147, be=0xF, type1=1 -> cfg_mgmt_write and type1 high until done; ch_done[2] with rdata=0.
- Round-robin: all 4 ch_req high continuously from reset, done after 1 cycle -> grant order 0,1,2,3,0; strobe spacing exactly 3 cycles between accesses.
- Timeout: TIMEOUT_CYC=16, no done -> strobe high exactly 16 cycles; ch_done with ch_timeout=1; timeout_cnt=1. A late done is ignored. Saturation: with ERRCNT_W=2, 4 timeouts -> timeout_cnt=3.
- Reset mid-access: user_reset_n low 2 cycles during ACCESS -> strobe 0 at next edge, no ch_done, rr_ptr=0; after release ch1 req is granted normally.
- Done coincident with timeout edge (done at wait_cnt=TIMEOUT_CYC-1) -> ch_timeout=0, read data returned, timeout_cnt unchanged.
